// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eth_tx_arbiter_if : request/data bundle between frame sources and arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface eth_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] din;
  logic [NREQ-1:0]   dven;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_dven;
  logic              busy;
  logic [7:0]        timeout_cnt;
  logic [7:0]        trunc_cnt;
  logic [7:0]        drop_cnt;

  modport slave (
    input  req, din, dven,
    output grant, tx_data, tx_dven, busy, timeout_cnt, trunc_cnt, drop_cnt
  );

  modport master (
    output req, din, dven,
    input  grant, tx_data, tx_dven, busy, timeout_cnt, trunc_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eth_tx_arbiter : round-robin arbiter sharing one Ethernet TX byte stream
// Rev 1.0
// ---------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 64,
  parameter int MAXLEN  = 1518
) (
  input  wire logic      clk,
  input  wire logic      reset,
  eth_tx_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_dven_q, tx_dven_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [LW-1:0]   len_q, len_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            trunc_q, trunc_d;
  logic [NREQ-1:0] dven_prev_q;
  logic [7:0]      timeout_cnt_q, timeout_cnt_d;
  logic [7:0]      trunc_cnt_q, trunc_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [IW-1:0]   sel;
  logic            sel_vld;
  int              cand;
  logic [IW-1:0]   idx_inc;
  logic [7:0]      cur_din;
  logic            cur_dven;
  logic            cur_req;
  logic [NREQ-1:0] rise;
  logic [3:0]      rise_n;
  logic [8:0]      drop_sum;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Scan downwards so the lowest offset from the pointer wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (bus.req[IW'(cand)]) begin
        sel     = IW'(cand);
        sel_vld = 1'b1;
      end
    end
  end

  assign idx_inc  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
  assign cur_din  = 8'(bus.din >> {idx_q, 3'b000});
  assign cur_dven = bus.dven[idx_q];
  assign cur_req  = bus.req[idx_q];

  // Several sources may start a stray frame in the same cycle.
  always_comb begin
    rise     = bus.dven & ~dven_prev_q & ~grant_q;
    rise_n   = '0;
    for (int k = 0; k < NREQ; k++) rise_n = rise_n + {3'b000, rise[k]};
    drop_sum = {1'b0, drop_cnt_q} + {5'b00000, rise_n};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    tx_dven_d     = 1'b0;
    wait_d        = wait_q;
    len_d         = len_q;
    gap_d         = gap_q;
    trunc_d       = trunc_q;
    timeout_cnt_d = timeout_cnt_q;
    trunc_cnt_d   = trunc_cnt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (sel_vld) begin
          idx_d   = sel;
          grant_d = NREQ'(1) << sel;
          wait_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!cur_req) begin
          grant_d = '0;
          ptr_d   = idx_inc;
          state_d = S_IDLE;
        end else if (cur_dven) begin
          tx_data_d = cur_din;
          tx_dven_d = 1'b1;
          len_d     = LW'(1);
          trunc_d   = 1'b0;
          state_d   = S_XFER;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          grant_d       = '0;
          timeout_cnt_d = sat_inc(timeout_cnt_q);
          ptr_d         = idx_inc;
          state_d       = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!cur_dven) begin
          grant_d = '0;
          ptr_d   = idx_inc;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (trunc_q) begin
          tx_dven_d = 1'b0;
        end else if (len_q == LW'(MAXLEN)) begin
          // One byte beyond the limit: suppress the rest of this frame.
          trunc_d     = 1'b1;
          trunc_cnt_d = sat_inc(trunc_cnt_q);
        end else begin
          tx_data_d = cur_din;
          tx_dven_d = 1'b1;
          len_d     = len_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IFG - 1)) state_d = S_IDLE;
        else                       gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      grant_q       <= '0;
      tx_data_q     <= '0;
      tx_dven_q     <= 1'b0;
      wait_q        <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      trunc_q       <= 1'b0;
      dven_prev_q   <= '0;
      timeout_cnt_q <= '0;
      trunc_cnt_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      tx_dven_q     <= tx_dven_d;
      wait_q        <= wait_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      trunc_q       <= trunc_d;
      dven_prev_q   <= bus.dven;
      timeout_cnt_q <= timeout_cnt_d;
      trunc_cnt_q   <= trunc_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_dven     = tx_dven_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.timeout_cnt = timeout_cnt_q;
  assign bus.trunc_cnt   = trunc_cnt_q;
  assign bus.drop_cnt    = drop_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_eth_tx_arbiter : directed self-checking bench for eth_tx_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_eth_tx_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  eth_tx_arbiter_if #(.NREQ(2)) bus ();

  eth_tx_arbiter #(
    .NREQ(2), .IFG(12), .TIMEOUT(64), .MAXLEN(1518)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (bus.grant == 2'b00 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Drives one frame on source src; optionally the other source pulses
  // dven for three cycles starting at byte pulse_at.
  task automatic send_frame(input int src, input int len, input int pulse_at,
                            output int nvalid, output int nerr, output logic [1:0] g_last);
    logic [7:0] b;
    nvalid = 0;
    nerr   = 0;
    g_last = '0;
    for (int i = 0; i < len; i++) begin
      b = 8'(i * 7 + src * 128 + 3);
      bus.din[src*8 +: 8] = b;
      bus.dven[src]       = 1'b1;
      if (pulse_at >= 0) begin
        bus.din[(1-src)*8 +: 8] = 8'hEE;
        bus.dven[1-src]         = (i >= pulse_at && i < pulse_at + 3);
      end
      tick();
      if (bus.tx_dven) begin
        nvalid++;
        if (bus.tx_data !== b) nerr++;
      end
      g_last = bus.grant;
    end
    bus.dven[src] = 1'b0;
    tick();
  endtask

  initial begin
    int n, nv, ne;
    logic [1:0] gl;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.req  = '0;
    bus.din  = '0;
    bus.dven = '0;
    repeat (3) tick();
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_tx_dven", 32'(bus.tx_dven), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_counters", {8'd0, bus.timeout_cnt, bus.trunc_cnt, bus.drop_cnt}, 0);
    reset = 1'b0;

    // Single source 0, 64-byte frame
    bus.req = 2'b01;
    wait_grant(n);
    check("t1_grant_lat", n, 1);
    check("t1_grant", 32'(bus.grant), 1);
    check("t1_busy", 32'(bus.busy), 1);
    send_frame(0, 64, -1, nv, ne, gl);
    bus.req = 2'b00;
    check("t1_nvalid", nv, 64);
    check("t1_data_err", ne, 0);
    check("t1_end_grant", 32'(bus.grant), 0);
    check("t1_end_dven", 32'(bus.tx_dven), 0);
    wait_idle(n);
    check("t1_gap_len", n, 12);

    // Both requesting: alternating grants, fixed spacing between frames
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 2'b11;
    wait_grant(n);
    check("t2_first_lat", n, 1);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        wait_grant(n);
        check("t2_gap_to_grant", n, 13);
      end
      check("t2_grant", 32'(bus.grant), (f % 2 == 0) ? 1 : 2);
      send_frame(f % 2, 10, -1, nv, ne, gl);
      check("t2_nvalid", nv, 10);
      check("t2_data_err", ne, 0);
    end
    bus.req = 2'b00;
    wait_idle(n);
    check("t2_idle", n, 12);

    // Source 0 never sends: grant revoked after TIMEOUT cycles
    bus.req = 2'b11;
    wait_grant(n);
    check("t3_grant", 32'(bus.grant), 1);
    n = 0;
    while (bus.grant == 2'b01 && n < 300) begin
      tick();
      n++;
    end
    check("t3_grant_cycles", n, 64);
    check("t3_timeout_cnt", 32'(bus.timeout_cnt), 1);
    tick();
    check("t3_next_grant", 32'(bus.grant), 2);
    bus.req = 2'b10;
    send_frame(1, 3, -1, nv, ne, gl);
    bus.req = 2'b00;
    check("t3_nvalid", nv, 3);
    check("t3_data_err", ne, 0);
    wait_idle(n);

    // Oversize frame is truncated at MAXLEN
    bus.req = 2'b01;
    wait_grant(n);
    send_frame(0, 1600, -1, nv, ne, gl);
    check("t4_nvalid", nv, 1518);
    check("t4_data_err", ne, 0);
    check("t4_grant_held", 32'(gl), 1);
    check("t4_end_grant", 32'(bus.grant), 0);
    check("t4_trunc_cnt", 32'(bus.trunc_cnt), 1);
    wait_idle(n);
    check("t4_gap_len", n, 12);

    // Frame of exactly MAXLEN is not counted as truncated
    wait_grant(n);
    send_frame(0, 1518, -1, nv, ne, gl);
    bus.req = 2'b00;
    check("t4b_nvalid", nv, 1518);
    check("t4b_trunc_cnt", 32'(bus.trunc_cnt), 1);
    check("t4b_drop_cnt", 32'(bus.drop_cnt), 0);
    wait_idle(n);

    // Source 1 pulses dven while source 0 transfers
    bus.req = 2'b01;
    wait_grant(n);
    send_frame(0, 20, 5, nv, ne, gl);
    bus.req = 2'b00;
    check("t5_nvalid", nv, 20);
    check("t5_data_err", ne, 0);
    check("t5_drop_cnt", 32'(bus.drop_cnt), 1);
    wait_idle(n);

    // Reset in the middle of a frame
    bus.req = 2'b01;
    wait_grant(n);
    for (int i = 0; i < 50; i++) begin
      bus.din[7:0] = 8'(i);
      bus.dven[0]  = 1'b1;
      tick();
    end
    check("t6_mid_dven", 32'(bus.tx_dven), 1);
    reset = 1'b1;
    tick();
    check("t6_rst_dven", 32'(bus.tx_dven), 0);
    check("t6_rst_grant", 32'(bus.grant), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_counters", {8'd0, bus.timeout_cnt, bus.trunc_cnt, bus.drop_cnt}, 0);
    reset    = 1'b0;
    bus.dven = 2'b00;
    bus.req  = 2'b10;
    wait_grant(n);
    check("t6_grant_lat", n, 1);
    check("t6_grant", 32'(bus.grant), 2);
    send_frame(1, 4, -1, nv, ne, gl);
    bus.req = 2'b00;
    check("t6_nvalid", nv, 4);
    check("t6_data_err", ne, 0);
    wait_idle(n);
    check("t6_idle", n, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
